// File: rtl/instruction_aligner.sv
// instruction_aligner: fetch-side parcel buffer between instruction memory and decode.
// Accepts aligned fetch words, queues them as 16-bit parcels and hands decode one
// complete instruction per handshake (16-bit compressed or 32-bit, possibly straddling
// two fetch words). Also owns the fetch address counter and redirect handling.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i, flush_pc_i redirect request (highest priority) and halfword target
//   fetch_addr_o        address of the next fetch word (FetchBits/8 aligned)
//   fetch_valid_i/ready_o/data_i  fetch word handshake, little-endian parcels
//   instr_valid_o/ready_i         instruction handshake to decode
//   instr_o, instr_pc_o, compressed_o  instruction, its PC, 16-bit flag
module instruction_aligner #(
  parameter int unsigned        RegBits    = 32,
  parameter int unsigned        FetchBits  = 32,
  parameter int unsigned        BufParcels = 4,
  parameter logic [RegBits-1:0] ResetPc    = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [RegBits-1:0]   flush_pc_i,
  output logic [RegBits-1:0]   fetch_addr_o,
  input  logic                 fetch_valid_i,
  output logic                 fetch_ready_o,
  input  logic [FetchBits-1:0] fetch_data_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_o,
  output logic [RegBits-1:0]   instr_pc_o,
  output logic                 compressed_o
);

  localparam int unsigned FetchParcels = FetchBits / 16;
  localparam int unsigned OffBits      = $clog2(FetchBits / 8);
  localparam int unsigned SkipBits     = OffBits - 1;
  localparam int unsigned PtrBits      = $clog2(BufParcels);
  localparam int unsigned CntBits      = $clog2(BufParcels + 1);

  localparam logic [RegBits-1:0] AlignMask  = {{(RegBits - OffBits){1'b1}}, {OffBits{1'b0}}};
  localparam logic [RegBits-1:0] HalfMask   = {{(RegBits - 1){1'b1}}, 1'b0};
  localparam logic [CntBits-1:0] ReadyLimit = CntBits'(BufParcels - FetchParcels);

  logic [15:0]         queue_q [BufParcels];
  logic [PtrBits-1:0]  head_q, head_d;
  logic [PtrBits-1:0]  tail_q, tail_d;
  logic [CntBits-1:0]  count_q, count_d;
  logic [RegBits-1:0]  pc_q, pc_d;
  logic [RegBits-1:0]  fetch_addr_q, fetch_addr_d;
  logic [SkipBits-1:0] skip_q, skip_d;

  logic [15:0]         h0, h1;
  logic                is32;
  logic                head_valid;
  logic                accept;
  logic                issue;
  logic [CntBits-1:0]  push_cnt;
  logic [CntBits-1:0]  pop_cnt;

  // Head decode: a 32-bit instruction needs both of its parcels queued.
  always_comb begin
    h0         = queue_q[head_q];
    h1         = queue_q[head_q + PtrBits'(1)];
    is32       = (h0[1:0] == 2'b11);
    head_valid = is32 ? (count_q >= CntBits'(2)) : (count_q != '0);
  end

  // Handshakes; readiness uses the pre-pop count and flush gates both sides.
  always_comb begin
    instr_valid_o = head_valid && !flush_i;
    fetch_ready_o = (count_q <= ReadyLimit) && !flush_i;
    accept        = fetch_valid_i && fetch_ready_o;
    issue         = instr_valid_o && instr_ready_i;
    push_cnt      = CntBits'(FetchParcels) - CntBits'(skip_q);
    pop_cnt       = is32 ? CntBits'(2) : CntBits'(1);
  end

  // Instruction outputs, zeroed whenever nothing is being offered.
  always_comb begin
    instr_o      = '0;
    compressed_o = 1'b0;
    if (instr_valid_o) begin
      instr_o      = is32 ? {h1, h0} : {16'h0000, h0};
      compressed_o = !is32;
    end
    instr_pc_o   = pc_q;
    fetch_addr_o = fetch_addr_q;
  end

  // Next-state: flush overrides; otherwise accept and issue apply together.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    skip_d       = skip_q;
    if (flush_i) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      pc_d         = flush_pc_i & HalfMask;
      fetch_addr_d = flush_pc_i & AlignMask;
      skip_d       = flush_pc_i[OffBits-1:1];
    end else begin
      if (accept) begin
        tail_d       = tail_q + PtrBits'(push_cnt);
        fetch_addr_d = fetch_addr_q + RegBits'(FetchBits / 8);
        skip_d       = '0;
      end
      if (issue) begin
        head_d = head_q + PtrBits'(pop_cnt);
        pc_d   = pc_q + (is32 ? RegBits'(4) : RegBits'(2));
      end
      count_d = count_q + (accept ? push_cnt : CntBits'(0)) - (issue ? pop_cnt : CntBits'(0));
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pc_q         <= ResetPc;
      fetch_addr_q <= ResetPc & AlignMask;
      skip_q       <= ResetPc[OffBits-1:1];
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
    end
  end

  // Parcel storage; skipped low parcels are not written and the rest pack from tail.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < int'(FetchParcels); i++) begin
        if (i >= int'(skip_q)) begin
          queue_q[tail_q + PtrBits'(i - int'(skip_q))] <= fetch_data_i[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_aligner.sv
module tb_instruction_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 32-bit fetch instance (BufParcels=4)
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_addr, instr, instr_pc;
  logic        fetch_ready, instr_valid, compressed;

  // 64-bit fetch instance (BufParcels=8)
  logic        flush64 = 1'b0;
  logic [31:0] flush_pc64 = '0;
  logic        fetch_valid64 = 1'b0;
  logic [63:0] fetch_data64 = '0;
  logic        instr_ready64 = 1'b0;
  logic [31:0] fetch_addr64, instr64, instr_pc64;
  logic        fetch_ready64, instr_valid64, compressed64;

  int tests_run = 0;
  int tests_failed = 0;

  // {valid, compressed, fetch_ready, instr, instr_pc, fetch_addr}
  logic [98:0] obs32, obs64, want;
  assign obs32 = {instr_valid, compressed, fetch_ready, instr, instr_pc, fetch_addr};
  assign obs64 = {instr_valid64, compressed64, fetch_ready64, instr64, instr_pc64, fetch_addr64};

  instruction_aligner #(.RegBits(32), .FetchBits(32), .BufParcels(4), .ResetPc(32'h0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flush_pc),
    .fetch_addr_o(fetch_addr), .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_data_i(fetch_data), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .compressed_o(compressed)
  );

  instruction_aligner #(.RegBits(32), .FetchBits(64), .BufParcels(8), .ResetPc(32'h0)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64), .flush_pc_i(flush_pc64),
    .fetch_addr_o(fetch_addr64), .fetch_valid_i(fetch_valid64), .fetch_ready_o(fetch_ready64),
    .fetch_data_i(fetch_data64), .instr_valid_o(instr_valid64), .instr_ready_i(instr_ready64),
    .instr_o(instr64), .instr_pc_o(instr_pc64), .compressed_o(compressed64)
  );

  always #5 clk = ~clk;

  // Drive the 32-bit instance for the next edge; returns 1ns after the falling edge.
  task automatic cyc32(input logic fv, input logic [31:0] fd, input logic rdy,
                       input logic fl, input logic [31:0] fpc);
    @(negedge clk);
    fetch_valid = fv; fetch_data = fd; instr_ready = rdy; flush = fl; flush_pc = fpc;
    #1;
  endtask

  task automatic cyc64(input logic fv, input logic [63:0] fd, input logic rdy,
                       input logic fl, input logic [31:0] fpc);
    @(negedge clk);
    fetch_valid64 = fv; fetch_data64 = fd; instr_ready64 = rdy; flush64 = fl; flush_pc64 = fpc;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_valid = 1'b0; instr_ready = 1'b0; flush = 1'b0;
    fetch_valid64 = 1'b0; instr_ready64 = 1'b0; flush64 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h0, 32'h0};
    if (obs32 !== want) begin tests_failed++; $display("FAIL reset32: got %h want %h", obs32, want); end
    tests_run++;
    if (obs64 !== want) begin tests_failed++; $display("FAIL reset64: got %h want %h", obs64, want); end
    rst = 1'b0;
  endtask

  task automatic test_single32();
    apply_reset();
    cyc32(1'b1, 32'h00A00093, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h0, 32'h0};
    if (obs32 !== want) begin tests_failed++; $display("FAIL single32_empty: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b101, 32'h00A00093, 32'h0, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL single32_issue: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h4, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL single32_after: got %h want %h", obs32, want); end
  endtask

  task automatic test_compressed_pair();
    apply_reset();
    cyc32(1'b1, 32'h45014505, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h0, 32'h0};
    if (obs32 !== want) begin tests_failed++; $display("FAIL pair_empty: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004505, 32'h0, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL pair_first: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004501, 32'h2, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL pair_second: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h4, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL pair_drained: got %h want %h", obs32, want); end
  endtask

  task automatic test_straddle();
    apply_reset();
    cyc32(1'b1, 32'h00934505, 1'b1, 1'b0, 32'h0);
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004505, 32'h0, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_c: got %h want %h", obs32, want); end
    for (int k = 0; k < 3; k++) begin
      cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tests_run++; want = {3'b001, 32'h0, 32'h2, 32'h4};
      if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_gap%0d: got %h want %h", k, obs32, want); end
    end
    cyc32(1'b1, 32'h000100A0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h2, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_accept: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b100, 32'h00A00093, 32'h2, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_32: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00000001, 32'h6, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_tail: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h8, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL straddle_end: got %h want %h", obs32, want); end
  endtask

  task automatic test_flush();
    apply_reset();
    cyc32(1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
    tests_run++; want = {3'b000, 32'h0, 32'h0, 32'h0};
    if (obs32 !== want) begin tests_failed++; $display("FAIL flush_gate: got %h want %h", obs32, want); end
    cyc32(1'b1, 32'h4505ABCD, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h102, 32'h100};
    if (obs32 !== want) begin tests_failed++; $display("FAIL flush_target: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004505, 32'h102, 32'h104};
    if (obs32 !== want) begin tests_failed++; $display("FAIL flush_skip: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b1, 32'h2003);
    tests_run++; want = {3'b000, 32'h0, 32'h104, 32'h104};
    if (obs32 !== want) begin tests_failed++; $display("FAIL flush_odd_gate: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h2002, 32'h2000};
    if (obs32 !== want) begin tests_failed++; $display("FAIL flush_odd_target: got %h want %h", obs32, want); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    cyc32(1'b1, 32'h11110013, 1'b0, 1'b0, 32'h0);
    cyc32(1'b1, 32'h22220013, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b101, 32'h11110013, 32'h0, 32'h4};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_second: got %h want %h", obs32, want); end
    cyc32(1'b1, 32'h33330013, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b100, 32'h11110013, 32'h0, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_full: got %h want %h", obs32, want); end
    cyc32(1'b1, 32'h33330013, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b100, 32'h11110013, 32'h0, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_full_pop: got %h want %h", obs32, want); end
    cyc32(1'b1, 32'h33330013, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b101, 32'h22220013, 32'h4, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_reopen: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b101, 32'h33330013, 32'h8, 32'hC};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_third: got %h want %h", obs32, want); end
    cyc32(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'hC, 32'hC};
    if (obs32 !== want) begin tests_failed++; $display("FAIL bp_drained: got %h want %h", obs32, want); end
  endtask

  task automatic test_flush_full();
    apply_reset();
    cyc32(1'b1, 32'h11110013, 1'b0, 1'b0, 32'h0);
    cyc32(1'b1, 32'h22220013, 1'b0, 1'b0, 32'h0);
    cyc32(1'b1, 32'h33330013, 1'b1, 1'b1, 32'h40);
    tests_run++; want = {3'b000, 32'h0, 32'h0, 32'h8};
    if (obs32 !== want) begin tests_failed++; $display("FAIL ff_flush: got %h want %h", obs32, want); end
    for (int k = 0; k < 2; k++) begin
      cyc32(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tests_run++; want = {3'b001, 32'h0, 32'h40, 32'h40};
      if (obs32 !== want) begin tests_failed++; $display("FAIL ff_after%0d: got %h want %h", k, obs32, want); end
    end
  endtask

  task automatic test_fetch64();
    apply_reset();
    cyc64(1'b0, 64'h0, 1'b0, 1'b1, 32'h206);
    tests_run++; want = {3'b000, 32'h0, 32'h0, 32'h0};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_flush: got %h want %h", obs64, want); end
    cyc64(1'b1, 64'h4505_0093_1111_2222, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h206, 32'h200};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_target: got %h want %h", obs64, want); end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004505, 32'h206, 32'h208};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_skip3: got %h want %h", obs64, want); end
    cyc64(1'b1, 64'h00A0_0093_4501_4505, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b001, 32'h0, 32'h208, 32'h208};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_empty: got %h want %h", obs64, want); end
    cyc64(1'b1, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00004505, 32'h208, 32'h210};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_half: got %h want %h", obs64, want); end
    cyc64(1'b1, 64'h0001_0001_0001_0001, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b110, 32'h00004505, 32'h208, 32'h218};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_full: got %h want %h", obs64, want); end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b110, 32'h00004501, 32'h20A, 32'h218};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_c2: got %h want %h", obs64, want); end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
    tests_run++; want = {3'b100, 32'h00A00093, 32'h20C, 32'h218};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_32: got %h want %h", obs64, want); end
    cyc64(1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
    tests_run++; want = {3'b111, 32'h00000001, 32'h210, 32'h218};
    if (obs64 !== want) begin tests_failed++; $display("FAIL f64_reopen: got %h want %h", obs64, want); end
  endtask

  // Random traffic against a parcel-queue reference model (32-bit fetch instance).
  task automatic test_random();
    logic [15:0] mq[$];
    logic [31:0] m_pc, m_addr, fd, fpc;
    logic        m_skip, fv, rdy, fl, e_has, e_valid, e_fr, e_32;
    logic [31:0] e_instr;
    apply_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_skip = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      fv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      fd  = $urandom;
      fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFFF);
      @(negedge clk);
      rst = (i == 1500);
      fetch_valid = fv; fetch_data = fd; instr_ready = rdy; flush = fl; flush_pc = fpc;
      #1;
      if (rst) begin
        mq.delete(); m_pc = 32'h0; m_addr = 32'h0; m_skip = 1'b0;
      end
      e_32    = (mq.size() >= 1) && (mq[0][1:0] == 2'b11);
      e_has   = e_32 ? (mq.size() >= 2) : (mq.size() >= 1);
      e_valid = e_has && !fl;
      e_fr    = (mq.size() <= 2) && !fl;
      e_instr = !e_valid ? 32'h0 : (e_32 ? {mq[1], mq[0]} : {16'h0, mq[0]});
      tests_run++; want = {e_valid, e_valid && !e_32, e_fr, e_instr, m_pc, m_addr};
      if (obs32 !== want) begin
        tests_failed++; $display("FAIL random_cyc%0d: got %h want %h", i, obs32, want);
      end
      if (!rst) begin
        if (fl) begin
          mq.delete();
          m_pc = fpc & ~32'h1; m_addr = fpc & ~32'h3; m_skip = fpc[1];
        end else begin
          if (e_valid && rdy) begin
            void'(mq.pop_front());
            if (e_32) void'(mq.pop_front());
            m_pc = m_pc + (e_32 ? 32'd4 : 32'd2);
          end
          if (fv && e_fr) begin
            if (!m_skip) mq.push_back(fd[15:0]);
            mq.push_back(fd[31:16]);
            m_addr = m_addr + 32'd4;
            m_skip = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; fetch_valid = 1'b0; instr_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single32();
    test_compressed_pair();
    test_straddle();
    test_flush();
    test_backpressure();
    test_flush_full();
    test_fetch64();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_aligner.md
# instruction_aligner

Fetch-side parcel buffer between instruction memory and the decode stage. It accepts aligned fetch words, queues them as 16-bit parcels, and presents exactly one complete instruction per handshake, either a 16-bit compressed parcel or a 32-bit instruction. A 32-bit instruction may straddle two fetch words. The block also owns the fetch address counter and handles control-flow redirects to any halfword-aligned PC.

## Interface
Parameters:
- RegBits, 32: PC/address width.
- FetchBits, 32: fetch word width. Legal values are 32 or 64. FetchParcels = FetchBits/16.
- BufParcels, 4: queue depth in 16-bit parcels. Must be a power of two and ≥ 2*FetchParcels.
- ResetPc, 0: PC after reset. Must be halfword aligned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  redirect request; highest priority.
- flush_pc_i  in  RegBits  redirect target; bit 0 is ignored.
- fetch_addr_o  out  RegBits  address of the next fetch word, aligned to FetchBits/8.
- fetch_valid_i  in  1  fetch_data_i holds the word at fetch_addr_o.
- fetch_ready_o  out  1  block accepts the fetch word this cycle.
- fetch_data_i  in  FetchBits  fetch word, little-endian parcels.
- instr_valid_o  out  1  instr_o/instr_pc_o hold a complete instruction.
- instr_ready_i  in  1  decode consumes the instruction.
- instr_o  out  32  instruction. Compressed: {16'h0, parcel}. Zero when instr_valid_o=0.
- instr_pc_o  out  RegBits  PC of instr_o.
- compressed_o  out  1  instr_o is 16-bit; the next PC is +2. Zero when not valid.

## Operation
- State:
  - Circular parcel queue with head and tail pointers of log2(BufParcels) bits, wrapping modulo BufParcels.
  - count (0..BufParcels).
  - pc_q: PC of the head parcel.
  - fetch_addr_q.
  - skip_q (0..FetchParcels-1): number of low parcels to drop from the next accepted word.
- Head decode, with h0 = queue[head] and h1 = queue[head+1]:
  - h0[1:0] != 2'b11 and count ≥ 1: valid, compressed, instr_o = {16'h0, h0}.
  - h0[1:0] == 2'b11 and count ≥ 2: valid, 32-bit, instr_o = {h1, h0}.
  - Otherwise not valid. This covers empty, and a 32-bit instruction whose upper half has not arrived.
- instr_valid_o = head-decode valid && !flush_i.
- fetch_ready_o = (count ≤ BufParcels − FetchParcels) && !flush_i.
- Fetch accept (fetch_valid_i && fetch_ready_o):
  - Push parcels skip_q..FetchParcels-1 in ascending order.
  - count += FetchParcels − skip_q.
  - fetch_addr_q += FetchBits/8.
  - skip_q ← 0.
- Issue (instr_valid_o && instr_ready_i):
  - Pop 1 parcel (compressed) or 2 parcels (32-bit).
  - pc_q += 2 or 4, wrapping modulo 2^RegBits.
- Accept and issue in the same cycle are both applied; count changes by the net amount. The readiness check uses the pre-pop count, so no bypass.
- Flush, synchronous, overrides every other update in the same cycle:
  - count ← 0 and head = tail ← 0.
  - pc_q ← {flush_pc_i[RegBits-1:1], 1'b0}.
  - fetch_addr_q ← flush_pc_i with low log2(FetchBits/8) bits cleared.
  - skip_q ← flush_pc_i[log2(FetchBits/8)-1:1].
  - Any fetch word or issue in that cycle is discarded (both handshakes are gated low).
- Illegal all-zero parcels are passed through unchanged; decode flags them.

## Timing
- Reset values, asynchronous:
  - count 0, pc_q = ResetPc, fetch_addr_q = ResetPc aligned, skip_q = ResetPc[log2(FetchBits/8)-1:1].
  - Outputs: instr_valid_o 0, instr_o 0, compressed_o 0, instr_pc_o = ResetPc, fetch_ready_o 1 (with flush_i=0).
- Reset mid-operation discards all queued parcels immediately.
- Latency: a fetch word accepted at edge N yields instr_valid_o after edge N. There is no combinational path from fetch_data_i to instr_o.
- Straddling 32-bit instruction: instr_valid_o stays 0 until the word holding the upper parcel is accepted, then rises the next cycle.
- Outputs are held stable while instr_valid_o=1 and instr_ready_i=0. The exception is flush_i, which drops instr_valid_o in the same cycle.
- Full: when count > BufParcels − FetchParcels, fetch_ready_o=0. Accept and pop are never simultaneous at full.
- Throughput: one instruction per cycle when the queue holds a complete instruction.

## Test plan
- Reset, ResetPc=0, FetchBits=32; word 0x00A00093 → one issue: instr_o=0x00A00093, instr_pc_o=0x0, compressed_o=0; next instr_pc_o=0x4.
- Word 0x45014505 with instr_ready_i=1 → cycle 1: instr_o=0x00004505, pc 0x0, compressed_o=1. Cycle 2: instr_o=0x00004501, pc 0x2.
- Straddle: word 0x00934505 then, 3 idle cycles later, word 0x000100A0 → 0x4505 at pc 0x0. instr_valid_o=0 during the gap. Then 0x00A00093 at pc 0x2.
- Flush to 0x102 → fetch_addr_o=0x100. Word 0x4505ABCD → instr_o=0x00004505, pc 0x102; parcel 0xABCD is dropped. Next fetch_addr_o=0x104.
- Backpressure, BufParcels=4, instr_ready_i=0: stream 32-bit-aligned words → after 2 accepts, count=4 and fetch_ready_o=0. Raise instr_ready_i → fetch_ready_o returns to 1 after the first pop.
- Full queue plus flush_i and fetch_valid_i in the same cycle → no accept, instr_valid_o=0 that cycle and the next. instr_pc_o equals the flush target. FetchBits=64 variant: flush to 0x206 → skip_q=3, only parcel 3 of the word at 0x200 is pushed.
